// File: rtl/tetris_pkg.sv
// Shared piece definitions for the piece queue: piece and state encodings,
// the 7x4x4 shape table and the preview bitmap placement.
package tetris_pkg;

    localparam int unsigned NUM_PIECES  = 7;
    localparam int unsigned PIECE_W     = 3;
    localparam int unsigned BAG_W       = NUM_PIECES;
    localparam int unsigned LFSR_W      = 16;
    localparam int unsigned TRY_W       = 4;
    localparam int unsigned MAX_TRIES   = 8;
    localparam int unsigned MAP_ROWS    = 12;
    localparam int unsigned MAP_COLS    = 10;
    localparam int unsigned SHAPE_DIM   = 4;
    localparam int unsigned PREVIEW_ROW = 4;
    localparam int unsigned PREVIEW_COL = 3;

    typedef enum logic [PIECE_W-1:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_DRAW = 2'd2
    } state_e;

    typedef logic [MAP_ROWS-1:0][MAP_COLS-1:0] preview_map_t;

    // Indexed [piece][row][col]; col bit 0 lands on preview column PREVIEW_COL.
    localparam logic [0:NUM_PIECES-1][0:SHAPE_DIM-1][SHAPE_DIM-1:0] SHAPE_TABLE = {
        4'b0000, 4'b1111, 4'b0000, 4'b0000,   // I
        4'b0000, 4'b0110, 4'b0110, 4'b0000,   // O
        4'b0000, 4'b0111, 4'b0010, 4'b0000,   // T
        4'b0000, 4'b0110, 4'b0011, 4'b0000,   // S
        4'b0000, 4'b0011, 4'b0110, 4'b0000,   // Z
        4'b0000, 4'b0111, 4'b0100, 4'b0000,   // J
        4'b0000, 4'b0111, 4'b0001, 4'b0000    // L
    };

    // Fibonacci LFSR step, taps 16,14,13,11.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/piece_bitmap.sv
// Expands a piece type into a 12x10 preview bitmap; blank when disabled.
module piece_bitmap
    import tetris_pkg::*;
(
    input  logic [PIECE_W-1:0] piece_i,
    input  logic               en_i,
    output preview_map_t       map_o
);

    // Stamp the 4x4 shape into the fixed preview window.
    always_comb begin
        map_o = '0;
        if (en_i && (piece_i < PIECE_W'(NUM_PIECES))) begin
            for (int r = 0; r < SHAPE_DIM; r++) begin
                for (int c = 0; c < SHAPE_DIM; c++) begin
                    map_o[PREVIEW_ROW + r][PREVIEW_COL + c] = SHAPE_TABLE[piece_i][r][c];
                end
            end
        end
    end

endmodule

// File: rtl/piece_queue.sv
// Piece queue for the game FSM: active/next/hold pieces, 7-bag drawing and
// preview bitmaps. Macro PIECE_QUEUE_RANDOM_EN selects the LFSR-driven bag;
// without it pieces are drawn in fixed order 0..6.
module piece_queue
    import tetris_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               spawn_req,
    input  logic               hold_req,
    output logic               ready,
    output logic               piece_valid,
    output logic [PIECE_W-1:0] active_type,
    output logic [PIECE_W-1:0] next_type,
    output logic               hold_valid,
    output logic [PIECE_W-1:0] hold_type,
    output preview_map_t       next_map,
    output preview_map_t       swap_map
);

    state_e               state_q, state_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [PIECE_W-1:0]   active_q, active_d;
    logic [PIECE_W-1:0]   next_q, next_d;
    logic [PIECE_W-1:0]   hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic                 hold_allowed_q, hold_allowed_d;
    logic                 piece_valid_q, piece_valid_d;

    logic                 drawing;
    logic                 draw_done;
    logic [PIECE_W-1:0]   draw_piece;

    assign lfsr_d  = lfsr_step(lfsr_q);
    assign drawing = (state_q == ST_INIT) || (state_q == ST_DRAW);

`ifdef PIECE_QUEUE_RANDOM_EN
    logic [BAG_W-1:0]     used_q, used_d;
    logic [BAG_W-1:0]     used_set;
    logic [BAG_W:0]       used_ext;
    logic [TRY_W-1:0]     tries_q, tries_d;
    logic [PIECE_W-1:0]   cand;
    logic [PIECE_W-1:0]   lowest;

    assign cand     = lfsr_q[PIECE_W-1:0];
    assign used_ext = {1'b1, used_q};   // index 7 is never a valid piece

    // Lowest unused bag slot, used once the retry budget runs out.
    always_comb begin
        lowest = '0;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (!used_q[i]) lowest = PIECE_W'(i);
        end
    end

    // One candidate per cycle; forced pick after MAX_TRIES rejections.
    always_comb begin
        draw_done  = 1'b0;
        draw_piece = cand;
        tries_d    = tries_q;
        used_d     = used_q;
        used_set   = '0;
        if (drawing) begin
            if (tries_q >= TRY_W'(MAX_TRIES)) begin
                draw_done  = 1'b1;
                draw_piece = lowest;
            end else if (!used_ext[cand]) begin
                draw_done  = 1'b1;
            end else begin
                tries_d    = tries_q + 1'b1;
            end
            if (draw_done) begin
                used_set = used_q | (BAG_W'(1) << draw_piece);
                used_d   = (used_set == '1) ? '0 : used_set;
                tries_d  = '0;
            end
        end
    end

    // Bag mask and retry counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            used_q  <= '0;
            tries_q <= '0;
        end else begin
            used_q  <= used_d;
            tries_q <= tries_d;
        end
    end
`else
    logic [PIECE_W-1:0]   seq_q, seq_d;

    assign draw_done  = drawing;
    assign draw_piece = seq_q;
    assign seq_d      = !drawing ? seq_q :
                        (seq_q == PIECE_W'(NUM_PIECES - 1)) ? '0 : seq_q + 1'b1;

    // Fixed-order sequence pointer.
    always_ff @(posedge Clk) begin
        if (Reset) seq_q <= '0;
        else       seq_q <= seq_d;
    end
`endif

    // Queue control: spawn, hold, swap and refill of the next piece.
    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        next_d         = next_q;
        hold_d         = hold_q;
        hold_valid_d   = hold_valid_q;
        hold_allowed_d = hold_allowed_q;
        piece_valid_d  = 1'b0;
        case (state_q)
            ST_INIT, ST_DRAW: begin
                if (draw_done) begin
                    next_d  = draw_piece;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (spawn_req) begin
                    active_d       = next_q;
                    piece_valid_d  = 1'b1;
                    hold_allowed_d = 1'b1;
                    state_d        = ST_DRAW;
                end else if (hold_req && hold_allowed_q) begin
                    hold_allowed_d = 1'b0;
                    piece_valid_d  = 1'b1;
                    hold_d         = active_q;
                    if (!hold_valid_q) begin
                        hold_valid_d = 1'b1;
                        active_d     = next_q;
                        state_d      = ST_DRAW;
                    end else begin
                        active_d     = hold_q;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and piece registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= ST_INIT;
            lfsr_q         <= SEED;
            active_q       <= PIECE_I;
            next_q         <= PIECE_I;
            hold_q         <= PIECE_I;
            hold_valid_q   <= 1'b0;
            hold_allowed_q <= 1'b0;
            piece_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            active_q       <= active_d;
            next_q         <= next_d;
            hold_q         <= hold_d;
            hold_valid_q   <= hold_valid_d;
            hold_allowed_q <= hold_allowed_d;
            piece_valid_q  <= piece_valid_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign piece_valid = piece_valid_q;
    assign active_type = active_q;
    assign next_type   = next_q;
    assign hold_valid  = hold_valid_q;
    assign hold_type   = hold_q;

    piece_bitmap u_next_map (
        .piece_i (next_q),
        .en_i    (1'b1),
        .map_o   (next_map)
    );

    piece_bitmap u_swap_map (
        .piece_i (hold_q),
        .en_i    (hold_valid_q),
        .map_o   (swap_map)
    );

endmodule

// File: tb/tb_piece_queue.sv
// Self-checking bench for piece_queue; build with PIECE_QUEUE_RANDOM_EN
// defined to exercise the LFSR bag instead of the fixed order.
module tb_piece_queue;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              spawn_req;
    logic              hold_req;
    logic              ready;
    logic              piece_valid;
    logic [2:0]        active_type;
    logic [2:0]        next_type;
    logic              hold_valid;
    logic [2:0]        hold_type;
    logic [11:0][9:0]  next_map;
    logic [11:0][9:0]  swap_map;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];
    bit         sb_en = 1'b1;

    // Bench-side model of the queue contents (fixed-order build).
    logic [2:0] m_active, m_next, m_hold, m_seq;
    logic       m_hv, m_allowed;

    always #5 Clk = ~Clk;

    piece_queue #(.SEED(16'hACE1)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .spawn_req   (spawn_req),
        .hold_req    (hold_req),
        .ready       (ready),
        .piece_valid (piece_valid),
        .active_type (active_type),
        .next_type   (next_type),
        .hold_valid  (hold_valid),
        .hold_type   (hold_type),
        .next_map    (next_map),
        .swap_map    (swap_map)
    );

    // Scoreboard: every piece_valid pulse consumes one expected active piece.
    always @(negedge Clk) begin
        if (piece_valid === 1'b1) begin
            if (sb_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_pulse: active_type=%0d with nothing expected", active_type);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    if (active_type !== e) begin
                        errors++;
                        $display("FAIL sb_active_type: got %0d expected %0d", active_type, e);
                    end
                end
            end else begin
                got_q.push_back(active_type);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge Clk);
        Reset = 1'b1;
        spawn_req = 1'b0;
        hold_req = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Reset = 1'b0;
        exp_q.delete();
        m_active = 3'd0; m_hold = 3'd0; m_hv = 1'b0; m_allowed = 1'b0;
        m_next = 3'd0; m_seq = 3'd1;
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge Clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b after 20 cycles, required 1", ready);
        end
    endtask

    // Drive one request for a single cycle and advance the model.
    task automatic issue(input bit s, input bit h);
        bit draw;
        draw = 1'b0;
        @(negedge Clk);
        spawn_req = s;
        hold_req = h;
        @(posedge Clk);
        #1;
        spawn_req = 1'b0;
        hold_req = 1'b0;
        if (s) begin
            if (sb_en) exp_q.push_back(m_next);
            m_active = m_next;
            m_allowed = 1'b1;
            draw = 1'b1;
        end else if (h && m_allowed) begin
            m_allowed = 1'b0;
            if (!m_hv) begin
                if (sb_en) exp_q.push_back(m_next);
                m_hold = m_active;
                m_hv = 1'b1;
                m_active = m_next;
                draw = 1'b1;
            end else begin
                logic [2:0] t;
                if (sb_en) exp_q.push_back(m_hold);
                t = m_active;
                m_active = m_hold;
                m_hold = t;
            end
        end
        if (draw) begin
            m_next = m_seq;
            m_seq = 3'((m_seq + 3'd1) % 7);
        end
    endtask

    task automatic test_reset();
        logic [11:0][9:0] exp_map;
        exp_map = '0;
        exp_map[5][6:3] = 4'hF;
        apply_reset();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready); end
        checks++; if (piece_valid !== 1'b0) begin errors++; $display("FAIL rst_piece_valid: got %b expected 0", piece_valid); end
        checks++; if (active_type !== 3'd0) begin errors++; $display("FAIL rst_active: got %0d expected 0", active_type); end
        checks++; if (hold_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid: got %b expected 0", hold_valid); end
        checks++; if (hold_type !== 3'd0) begin errors++; $display("FAIL rst_hold_type: got %0d expected 0", hold_type); end
        release_reset();
        wait_ready();
        checks++; if (hold_valid !== 1'b0) begin errors++; $display("FAIL init_hold_valid: got %b expected 0", hold_valid); end
        checks++; if (swap_map !== '0) begin errors++; $display("FAIL init_swap_map: got %h expected 0", swap_map); end
`ifndef PIECE_QUEUE_RANDOM_EN
        checks++; if (next_type !== 3'd0) begin errors++; $display("FAIL init_next: got %0d expected 0", next_type); end
        checks++; if (next_map !== exp_map) begin errors++; $display("FAIL init_next_map: got %h expected %h", next_map, exp_map); end
`endif
    endtask

`ifndef PIECE_QUEUE_RANDOM_EN
    task automatic test_spawn_order();
        logic [11:0][9:0] exp_map;
        apply_reset();
        release_reset();
        wait_ready();
        for (int k = 0; k < 8; k++) begin
            wait_ready();
            issue(1'b1, 1'b0);
            checks++; if (piece_valid !== 1'b1) begin errors++; $display("FAIL spawn_pulse[%0d]: got %b expected 1", k, piece_valid); end
            checks++; if (active_type !== 3'(k % 7)) begin errors++; $display("FAIL spawn_active[%0d]: got %0d expected %0d", k, active_type, k % 7); end
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL spawn_ready_low[%0d]: got %b expected 0", k, ready); end
        end
        wait_ready();
        exp_map = '0;
        exp_map[5][5:4] = 2'b11;
        exp_map[6][5:4] = 2'b11;
        checks++; if (next_type !== 3'd1) begin errors++; $display("FAIL order_next: got %0d expected 1", next_type); end
        checks++; if (next_map !== exp_map) begin errors++; $display("FAIL order_next_map_O: got %h expected %h", next_map, exp_map); end
    endtask

    task automatic test_hold();
        logic [11:0][9:0] exp_map;
        apply_reset();
        release_reset();
        wait_ready();
        issue(1'b1, 1'b0);
        wait_ready();
        issue(1'b0, 1'b1);
        checks++; if (piece_valid !== 1'b1) begin errors++; $display("FAIL hold_pulse: got %b expected 1", piece_valid); end
        checks++; if (active_type !== 3'd1) begin errors++; $display("FAIL hold_active: got %0d expected 1", active_type); end
        checks++; if (hold_type !== 3'd0) begin errors++; $display("FAIL hold_type: got %0d expected 0", hold_type); end
        checks++; if (hold_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", hold_valid); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_draw: ready got %b expected 0", ready); end
        wait_ready();
        checks++; if (next_type !== 3'd2) begin errors++; $display("FAIL hold_next: got %0d expected 2", next_type); end
        exp_map = '0;
        exp_map[5][6:3] = 4'hF;
        checks++; if (swap_map !== exp_map) begin errors++; $display("FAIL hold_swap_map: got %h expected %h", swap_map, exp_map); end
        issue(1'b0, 1'b1);
        checks++; if (piece_valid !== 1'b0) begin errors++; $display("FAIL hold2_pulse: got %b expected 0", piece_valid); end
        checks++; if (active_type !== 3'd1) begin errors++; $display("FAIL hold2_active: got %0d expected 1", active_type); end
        checks++; if (hold_type !== 3'd0) begin errors++; $display("FAIL hold2_hold: got %0d expected 0", hold_type); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hold2_ready: got %b expected 1", ready); end
    endtask

    task automatic test_swap();
        wait_ready();
        issue(1'b1, 1'b0);
        checks++; if (active_type !== 3'd2) begin errors++; $display("FAIL swap_spawn_active: got %0d expected 2", active_type); end
        wait_ready();
        issue(1'b0, 1'b1);
        checks++; if (piece_valid !== 1'b1) begin errors++; $display("FAIL swap_pulse: got %b expected 1", piece_valid); end
        checks++; if (active_type !== 3'd0) begin errors++; $display("FAIL swap_active: got %0d expected 0", active_type); end
        checks++; if (hold_type !== 3'd2) begin errors++; $display("FAIL swap_hold: got %0d expected 2", hold_type); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL swap_ready: got %b expected 1", ready); end
        checks++; if (next_type !== 3'd3) begin errors++; $display("FAIL swap_next: got %0d expected 3", next_type); end
        checks++; if (active_type !== m_active) begin errors++; $display("FAIL swap_model_active: got %0d expected %0d", active_type, m_active); end
    endtask

    task automatic test_same_cycle_and_reset();
        apply_reset();
        release_reset();
        wait_ready();
        issue(1'b1, 1'b1);
        checks++; if (active_type !== 3'd0) begin errors++; $display("FAIL both_active: got %0d expected 0", active_type); end
        checks++; if (hold_valid !== 1'b0) begin errors++; $display("FAIL both_hold_valid: got %b expected 0", hold_valid); end
        wait_ready();
        checks++; if (hold_valid !== 1'b0) begin errors++; $display("FAIL both_hold_valid_later: got %b expected 0", hold_valid); end
        checks++; if (next_type !== 3'd1) begin errors++; $display("FAIL both_next: got %0d expected 1", next_type); end
        issue(1'b1, 1'b0);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL middraw_in_draw: ready got %b expected 0", ready); end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL middraw_ready: got %b expected 0", ready); end
        checks++; if (active_type !== 3'd0) begin errors++; $display("FAIL middraw_active: got %0d expected 0", active_type); end
        checks++; if (piece_valid !== 1'b0) begin errors++; $display("FAIL middraw_pulse: got %b expected 0", piece_valid); end
        checks++; if (hold_valid !== 1'b0) begin errors++; $display("FAIL middraw_hold_valid: got %b expected 0", hold_valid); end
        release_reset();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL middraw_init_ready: got %b expected 0", ready); end
        wait_ready();
        checks++; if (next_type !== 3'd0) begin errors++; $display("FAIL middraw_next: got %0d expected 0", next_type); end
    endtask
`else
    task automatic test_random_bag();
        logic [6:0] mask;
        int n;
        apply_reset();
        release_reset();
        wait_ready();
        sb_en = 1'b0;
        got_q.delete();
        for (int k = 0; k < 700; k++) begin
            wait_ready();
            issue(1'b1, 1'b0);
            n = 0;
            while (ready !== 1'b1 && n < 20) begin
                @(posedge Clk);
                #1;
                n++;
            end
            checks++;
            if (n > 9) begin
                errors++;
                $display("FAIL draw_length[%0d]: got %0d cycles, required at most 9", k, n);
            end
        end
        checks++;
        if (got_q.size() != 700) begin
            errors++;
            $display("FAIL bag_count: got %0d pulses expected 700", got_q.size());
        end else begin
            for (int g = 0; g < 100; g++) begin
                mask = '0;
                for (int j = 0; j < 7; j++) begin
                    if (got_q[7*g+j] < 3'd7) mask = mask | (7'd1 << got_q[7*g+j]);
                end
                checks++;
                if (mask !== 7'h7F) begin
                    errors++;
                    $display("FAIL bag_perm[%0d]: got mask %b expected 1111111", g, mask);
                end
            end
        end
        sb_en = 1'b1;
    endtask
`endif

    initial begin
        Reset = 1'b1;
        spawn_req = 1'b0;
        hold_req = 1'b0;
        test_reset();
`ifdef PIECE_QUEUE_RANDOM_EN
        test_random_bag();
`else
        test_spawn_order();
        test_hold();
        test_swap();
        test_same_cycle_and_reset();
`endif
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, meaning the nonzero LFSR reset value.
REQ-002 SHALL have port Clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port spawn_req, input, 1, one-cycle request from the game FSM for a new falling piece.
REQ-005 SHALL have port hold_req, input, 1, one-cycle request to swap the active piece with the hold slot.
REQ-006 SHALL have port ready, output, 1, high when a request will be accepted this cycle.
REQ-007 SHALL have port piece_valid, output, 1, one-cycle pulse marking a new active_type.
REQ-008 SHALL have port active_type, output, 3, piece now falling (0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L).
REQ-009 SHALL have port next_type, output, 3, preview piece.
REQ-010 SHALL have port hold_valid, output, 1, hold slot occupied; hold_type, output, 3, held piece.
REQ-011 SHALL have ports next_map and swap_map, output, 12 rows x 10 bits each, preview bitmaps for the next-piece and swap-piece draw mappers.

Function
REQ-012 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle outside Reset.
REQ-013 SHALL implement states INIT, IDLE, DRAW; ready high only in IDLE.
REQ-014 SHALL implement a 7-bag: 7-bit used mask, candidate = lfsr[2:0], accepted only if < 7 and not used.
REQ-015 SHALL, in DRAW, retry one candidate per cycle; after 8 rejected tries take the lowest unused index, bounding DRAW to 9 cycles.
REQ-016 SHALL set the accepted piece's used bit and clear the mask in the same cycle the seventh bit would be set.
REQ-017 SHALL, on spawn_req in IDLE: active_type <= next_type, piece_valid pulse next cycle, hold_allowed <= 1, enter DRAW to refill next_type.
REQ-018 SHALL, on hold_req in IDLE with hold_allowed and hold empty: hold_type <= active_type, hold_valid <= 1, active_type <= next_type, piece_valid pulse, enter DRAW.
REQ-019 SHALL, on hold_req in IDLE with hold_allowed and hold full: swap active_type and hold_type, piece_valid pulse, stay IDLE.
REQ-020 SHALL clear hold_allowed on any accepted hold; hold_req with hold_allowed low SHALL be ignored.
REQ-021 SHALL, for spawn_req and hold_req asserted together, service spawn_req only.
REQ-022 SHALL ignore requests while ready is low; no queuing.
REQ-023 SHALL derive next_map and swap_map combinationally from next_type and hold_type: shape in rows 4-7, columns 3-6, all else 0; swap_map all-zero when hold_valid low.

Reset
REQ-024 SHALL on Reset: LFSR <= SEED, used mask <= 0, hold_valid <= 0, hold_type <= 0, active_type <= 0, hold_allowed <= 0, piece_valid <= 0, state <= INIT.
REQ-025 SHALL in INIT draw next_type as in DRAW, then enter IDLE; ready low until then.
REQ-026 SHALL let Reset asserted mid-DRAW abandon the draw and restart from INIT.

Configuration
REQ-027 SHALL, with PIECE_QUEUE_RANDOM_EN defined, select pieces by LFSR bag per REQ-014..016.
REQ-028 SHALL, without PIECE_QUEUE_RANDOM_EN, draw pieces in fixed order 0,1,...,6,0,..., one cycle per DRAW, LFSR unused.

Structure
REQ-029 SHALL place the piece-type enum, the 7x4x4 shape table and preview row/column offsets in shared package tetris_pkg.
REQ-030 SHALL contain one sub-module piece_bitmap (type -> 12x10 map), instantiated twice.

Verification (macro undefined unless stated)
REQ-031 Reset then wait for ready -> next_type=0, hold_valid=0, swap_map all zero, next_map row 5 bits 3-6 set (I).
REQ-032 Seven spawn_req, each when ready -> active_type 0..6 in order with one piece_valid each; eighth gives 0.
REQ-033 spawn_req (active=0, next=1), hold_req -> hold_type=0, active_type=1, next_type=2; second hold_req ignored.
REQ-034 spawn_req, then hold_req with hold full -> active and hold swap, ready stays high, next_type unchanged.
REQ-035 spawn_req and hold_req same cycle -> only spawn serviced, hold_valid stays 0; Reset mid-DRAW -> INIT, outputs at reset values.
REQ-036 PIECE_QUEUE_RANDOM_EN defined, 700 spawns -> every consecutive aligned 7-group a permutation of 0..6, DRAW never exceeds 9 cycles.
